// File: rtl/rr_arb_pkg.sv
// Shared types for the round-robin stream arbiter.
// Two-state sequencer: IDLE arbitrates, BUSY forwards one burst.
package rr_arb_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// Rotated first-set-bit search over req[], starting at ptr.
// Walks offsets high to low so the smallest offset from ptr wins.
module rr_priority_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int j;

  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        any = 1'b1;
        idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// N:1 valid/ready stream arbiter, round-robin per burst.
// Grant is held from arbitration until the beat carrying last.
module rr_stream_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_last,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             busy;
  logic             xfer;

  rr_priority_pick #(.N(N)) u_pick (
    .req (in_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign busy = (state_q == BUSY);

  // Datapath mux is combinational so beats pass with zero latency.
  always_comb begin
    out_valid   = busy & in_valid[grant_q];
    out_last    = busy & in_last[grant_q];
    out_data    = busy ? in_data[int'(grant_q)*W +: W] : '0;
    in_ready    = busy ? (N'(out_ready) << grant_q) : '0;
    grant_valid = busy;
    grant_idx   = busy ? grant_q : '0;
  end

  assign xfer = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (pick_any) begin
          state_d = BUSY;
          grant_d = pick_idx;
        end
      end
      busy: begin
        if (xfer && out_last) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IDX_W'(N - 1)) ? '0
                                                : grant_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
